// File: rtl/serial_adder_frame.sv
// serial_adder_frame: framed LSB-first bit-serial adder/subtractor with per-frame overflow flag and saturating overflow count
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   EN        : consume LINE1/LINE2 this cycle (low = stall)
//   SYNC      : with EN, current bit is bit 0 of a new frame
//   SUB       : 0 = add, 1 = subtract; sampled at bit 0 only
//   LINE1     : serial operand A, LSB first
//   LINE2     : serial operand B, LSB first
//   OUTP      : registered sum/difference bit
//   OVERFLW   : one-cycle pulse, overflow of the just-completed frame
//   FRAME_END : one-cycle pulse with the frame MSB on OUTP
//   OVF_CNT   : saturating count of overflowed frames
module serial_adder_frame #(
    parameter int FRAME_LEN = 4,
    parameter bit SIGNED    = 0,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 EN,
    input  logic                 SYNC,
    input  logic                 SUB,
    input  logic                 LINE1,
    input  logic                 LINE2,
    output logic                 OUTP,
    output logic                 OVERFLW,
    output logic                 FRAME_END,
    output logic [OVF_CNT_W-1:0] OVF_CNT
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    logic [IW-1:0] bit_idx, idx_nxt;
    logic carry, sub_lat;
    logic first, last, mode, cin, b, s, cout, ovf;

    always_comb begin
        first   = SYNC || bit_idx == '0;
        last    = !SYNC && bit_idx == LAST;
        mode    = first ? SUB : sub_lat;
        // subtraction is A + ~B + 1, so the initial carry-in equals the mode bit
        cin     = first ? SUB : carry;
        b       = LINE2 ^ mode;
        s       = LINE1 ^ b ^ cin;
        cout    = (LINE1 & b) | (LINE1 & cin) | (b & cin);
        ovf     = SIGNED ? (cin ^ cout) : (mode ? ~cout : cout);
        idx_nxt = first ? IW'(1) : (last ? '0 : bit_idx + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= '0;
            carry     <= 1'b0;
            sub_lat   <= 1'b0;
            OUTP      <= 1'b0;
            OVERFLW   <= 1'b0;
            FRAME_END <= 1'b0;
            OVF_CNT   <= '0;
        end else if (EN) begin
            bit_idx   <= idx_nxt;
            carry     <= last ? 1'b0 : cout;
            sub_lat   <= mode;
            OUTP      <= s;
            FRAME_END <= last;
            OVERFLW   <= last & ovf;
            if (last && ovf && !(&OVF_CNT))
                OVF_CNT <= OVF_CNT + 1'b1;
        end else begin
            OVERFLW   <= 1'b0;
            FRAME_END <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_adder_frame.sv
// tb_serial_adder_frame: randomized and directed check of serial_adder_frame against an integer-arithmetic frame model
module tb_serial_adder_frame;
    logic clk = 0, rst_n = 0, en = 0, sync = 0, sub = 0, l1 = 0, l2 = 0;
    logic o0, v0, f0, o1, v1, f1, o2, v2, f2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    int total = 0, bad = 0;
    int k, a, b, n0, n1, n2;
    bit md, e_o, e_f, e_vu, e_vs;

    always #5 clk = ~clk;

    serial_adder_frame #(.FRAME_LEN(4), .SIGNED(0), .OVF_CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .EN(en), .SYNC(sync), .SUB(sub), .LINE1(l1), .LINE2(l2),
        .OUTP(o0), .OVERFLW(v0), .FRAME_END(f0), .OVF_CNT(c0));
    serial_adder_frame #(.FRAME_LEN(4), .SIGNED(1), .OVF_CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .EN(en), .SYNC(sync), .SUB(sub), .LINE1(l1), .LINE2(l2),
        .OUTP(o1), .OVERFLW(v1), .FRAME_END(f1), .OVF_CNT(c1));
    serial_adder_frame #(.FRAME_LEN(4), .SIGNED(0), .OVF_CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .EN(en), .SYNC(sync), .SUB(sub), .LINE1(l1), .LINE2(l2),
        .OUTP(o2), .OVERFLW(v2), .FRAME_END(f2), .OVF_CNT(c2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_rst;
        k = 0; a = 0; b = 0; md = 0;
        e_o = 0; e_f = 0; e_vu = 0; e_vs = 0;
        n0 = 0; n1 = 0; n2 = 0;
    endtask

    // Frame operands are accumulated as integers; each output bit is bit k of the
    // arithmetic result of the partial operands, overflow is judged on whole words.
    task automatic model_step;
        int r, sa, sb, sr;
        e_f = 0; e_vu = 0; e_vs = 0;
        if (!en) return;
        if (sync || k == 0) begin
            k = 0; a = 0; b = 0; md = sub;
        end
        a |= int'(l1) << k;
        b |= int'(l2) << k;
        r = md ? a - b : a + b;
        e_o = r[k];
        if (k == 3) begin
            e_f  = 1;
            e_vu = md ? (a < b) : (a + b > 15);
            sa = a > 7 ? a - 16 : a;
            sb = b > 7 ? b - 16 : b;
            sr = md ? sa - sb : sa + sb;
            e_vs = sr > 7 || sr < -8;
            if (e_vu && n0 < 255) n0++;
            if (e_vu && n2 < 3) n2++;
            if (e_vs && n1 < 255) n1++;
            k = 0;
        end else k++;
    endtask

    task automatic check_all;
        check("outp_u", o0, 32'(e_o));
        check("outp_s", o1, 32'(e_o));
        check("outp_w", o2, 32'(e_o));
        check("fend_u", f0, 32'(e_f));
        check("fend_s", f1, 32'(e_f));
        check("fend_w", f2, 32'(e_f));
        check("ovf_u", v0, 32'(e_vu));
        check("ovf_s", v1, 32'(e_vs));
        check("ovf_w", v2, 32'(e_vu));
        check("cnt_u", c0, 32'(n0));
        check("cnt_s", c1, 32'(n1));
        check("cnt_w", c2, 32'(n2));
    endtask

    task automatic cyc(input bit e, input bit s, input bit sb, input bit x, input bit y);
        en = e; sync = s; sub = sb; l1 = x; l2 = y;
        model_step;
        @(posedge clk);
        @(negedge clk);
        check_all;
    endtask

    task automatic frame(input logic [3:0] x, input logic [3:0] y, input bit sb);
        for (int i = 0; i < 4; i++) cyc(1, 0, sb, x[i], y[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_o"}, {o0, o1, o2}, 0);
        check({tag, "_v"}, {v0, v1, v2}, 0);
        check({tag, "_f"}, {f0, f1, f2}, 0);
        check({tag, "_c"}, {c0, c1, 6'(c2)}, 0);
    endtask

    initial begin
        logic [3:0] x, y;
        model_rst;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1;
        frame(4'd7, 4'd3, 0);
        check("sum_7p3_cnt", c0, 0);
        check("sum_7p3_scnt", c1, 1);
        frame(4'd15, 4'd1, 0);
        frame(4'd0, 4'd0, 0);
        x = 4'd3; y = 4'd5;
        for (int i = 0; i < 4; i++) cyc(1, 0, i < 2, x[i], y[i]);
        x = 4'd7; y = 4'd3;
        cyc(1, 0, 0, x[0], y[0]);
        cyc(1, 0, 0, x[1], y[1]);
        for (int i = 0; i < 3; i++) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        cyc(1, 0, 0, x[2], y[2]);
        cyc(1, 0, 0, x[3], y[3]);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, i == 0, 1, x[i], y[i]);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        for (int i = 1; i < 4; i++) cyc(1, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) frame(4'd15, 4'd1, 0);
        check("sat_w", c2, 3);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        #2 rst_n = 0;
        #1 check_zero("async_rst");
        model_rst;
        @(negedge clk);
        rst_n = 1;
        frame(4'd9, 4'd4, 0);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
